// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ps2_pkg                                                |
// | Brief   : Shared types and constants for the PS/2 receive FIFO.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ps2_pkg;

  localparam int PS2_DATA_W     = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Frame receiver states: start bit seen in IDLE, then 8 data bits,
  // the parity bit and finally the stop bit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ps2_sync_filter                                        |
// | Brief   : 2-flop synchronisers for ps2_clk/ps2_data, glitch      |
// |           filter on ps2_clk and a one-cycle falling-edge pulse.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int c_CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;
  logic               filt_q, filt_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               fall_q, fall_d;

  // Filtered level follows the synchronised clock only after it has
  // disagreed for FILTER_LEN consecutive samples; a fall emits a pulse.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    cnt_d       = '0;
    fall_d      = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == c_CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end
  end

  // State registers; everything resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall      = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ps2_rx_fifo                                            |
// | Brief   : PS/2 device-to-host frame receiver feeding a show-ahead|
// |           FIFO with sticky overflow and frame error pulse.       |
// |           Define PS2_RX_PARITY_CHECK_EN to reject frames with    |
// |           bad (even) parity.                                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  input  logic                    rd_en,
  input  logic                    overflow_clr,
  output logic [PS2_DATA_W-1:0]   data,
  output logic                    ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);

  logic w_data_s;
  logic w_sample;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (w_data_s),
    .fall      (w_sample)
  );

  ps2_state_t            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_W-1:0] shift_q, shift_d;
  logic [c_TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]    level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [PS2_DATA_W-1:0] mem_q [DEPTH];

  logic w_frame_done, w_frame_ok, w_parity_ok;
  logic w_full, w_push, w_pop, w_drop;

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_q, parity_d;
  // Odd parity over data+parity marks a good frame.
  assign w_parity_ok = ^{shift_q, parity_q};
`else
  // Parity bit is clocked through the PARITY state but never checked.
  assign w_parity_ok = 1'b1;
`endif

  // Frame receiver: next state, bit capture and inactivity timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    w_frame_done = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (w_sample && !w_data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_sample) begin
          shift_d[bit_cnt_q] = w_data_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_sample) begin
`ifdef PS2_RX_PARITY_CHECK_EN
          parity_d = w_data_s;
`endif
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_sample) begin
          state_d      = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any state past IDLE gives up after TIMEOUT_CYC quiet cycles.
    if (state_q != ST_IDLE) begin
      if (w_sample) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == c_TO_W'(TIMEOUT_CYC - 1)) begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + c_TO_W'(1);
      end
    end
  end

  assign w_frame_ok  = w_frame_done & w_data_s & w_parity_ok;
  assign frame_err_d = (w_frame_done & ~w_frame_ok) |
                       ((state_q != ST_IDLE) & ~w_sample &
                        (to_cnt_q == c_TO_W'(TIMEOUT_CYC - 1)));

  // FIFO bookkeeping: a full FIFO still accepts a push when popped the
  // same cycle, since the slot being freed is the one being written.
  always_comb begin
    w_full   = (level_q == c_LVL_W'(DEPTH));
    w_pop    = rd_en & (level_q != '0);
    w_push   = w_frame_ok & (~w_full | w_pop);
    w_drop   = w_frame_ok & w_full & ~w_pop;
    wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
    level_d  = level_q;
    if (w_push && !w_pop)      level_d = level_q + c_LVL_W'(1);
    else if (!w_push && w_pop) level_d = level_q - c_LVL_W'(1);
    overflow_d = overflow_q;
    if (w_drop)            overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Storage array; contents are only visible through a non-zero level.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign ready     = (level_q != '0);
  assign data      = ready ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ps2_rx_fifo                                         |
// | Brief   : Directed self-checking bench for ps2_rx_fifo.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH       = 8;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic [3:0] level;
  logic       overflow;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;

  ps2_rx_fifo #(
    .DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .overflow_clr(overflow_clr), .data(data),
    .ready(ready), .level(level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) err_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low phase. Optional
  // short low glitch in the high phase; optional pop on the push cycle.
  task automatic send_bit(input logic b, input bit glitch, input bit watch, output bit seen);
    seen = 1'b0;
    @(negedge clk) ps2_data = b;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 1 - 5 - (FILTER_LEN - 1)) @(negedge clk);
    end else begin
      repeat (HALF - 1) @(negedge clk);
    end
    ps2_clk = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      if (watch && !seen && dut.w_frame_ok) begin
        rd_en = 1'b1;
        seen  = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit, input bit pop_at_stop);
    logic [10:0] fr;
    bit seen;
    fr = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(fr[i], (i == glitch_bit), (pop_at_stop && i == 10), seen);
      if (pop_at_stop && i == 10) check("stop_push_seen", 32'(seen), 32'd1);
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  initial begin
    int  e0;
    bit  dummy;
    repeat (5) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame and pop
    send_frame(8'h1C, 1'b0, -1, 1'b0);
    check("f1c_ready", 32'(ready), 32'd1);
    check("f1c_data", 32'(data), 32'h1C);
    check("f1c_level", 32'(level), 32'd1);
    pop_one();
    check("pop_ready", 32'(ready), 32'd0);
    check("pop_data", 32'(data), 32'h00);
    pop_one();
    check("pop_empty_level", 32'(level), 32'd0);

    // Overflow with DEPTH+1 frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, -1, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_pop_data", 32'(data), 32'(i));
      pop_one();
    end
    check("ovf_drained", 32'(level), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk) overflow_clr = 1'b1;
    @(negedge clk) overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Wrong parity
    e0 = err_seen;
    send_frame(8'h5A, 1'b1, -1, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_err", 32'(err_seen - e0), 32'd1);
    check("par_level", 32'(level), 32'd0);
`else
    check("par_noerr", 32'(err_seen - e0), 32'd0);
    check("par_data", 32'(data), 32'h5A);
    pop_one();
`endif

    // Timeout after start bit + 4 data bits
    e0 = err_seen;
    send_bit(1'b0, 1'b0, 1'b0, dummy);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, dummy);
    repeat (TIMEOUT_CYC - 60) @(negedge clk);
    check("to_not_yet", 32'(err_seen - e0), 32'd0);
    check("to_busy", 32'(dut.state_q == ST_IDLE), 32'd0);
    repeat (TIMEOUT_CYC + 1) @(negedge clk);
    check("to_err", 32'(err_seen - e0), 32'd1);
    check("to_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
    check("to_level", 32'(level), 32'd0);
    send_frame(8'hF0, 1'b0, -1, 1'b0);
    check("to_next_data", 32'(data), 32'hF0);
    check("to_next_level", 32'(level), 32'd1);
    pop_one();

    // Full FIFO with pop coincident with push of 0x77
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, -1, 1'b0);
    check("full_level", 32'(level), 32'd8);
    send_frame(8'h77, 1'b0, -1, 1'b1);
    check("full_pp_level", 32'(level), 32'd8);
    check("full_pp_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check("full_pp_data", 32'(data), 32'h10 + 32'(i));
      pop_one();
    end
    check("full_pp_last", 32'(data), 32'h77);
    pop_one();
    check("full_pp_empty", 32'(level), 32'd0);

    // Short ps2_clk glitch inside a data bit
    e0 = err_seen;
    send_frame(8'h3A, 1'b0, 4, 1'b0);
    check("glitch_data", 32'(data), 32'h3A);
    check("glitch_level", 32'(level), 32'd1);
    check("glitch_noerr", 32'(err_seen - e0), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    send_bit(1'b0, 1'b0, 1'b0, dummy);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, dummy);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    e0 = err_seen;
    send_frame(8'h42, 1'b0, -1, 1'b0);
    check("post_rst_data", 32'(data), 32'h42);
    check("post_rst_level", 32'(level), 32'd1);
    check("post_rst_noerr", 32'(err_seen - e0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries; power of two, >=2.
REQ-002 Parameter FILTER_LEN, 4, consecutive clk samples ps2_clk must hold before a level change is accepted.
REQ-003 Parameter TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-008 rd_en  input  1  pop oldest entry when ready=1.
REQ-009 overflow_clr  input  1  clears sticky overflow.
REQ-010 data  output  8  oldest FIFO entry (show-ahead); 8'h00 when empty.
REQ-011 ready  output  1  FIFO non-empty.
REQ-012 level  output  $clog2(DEPTH)+1  current entry count.
REQ-013 overflow  output  1  sticky: a valid frame was dropped.
REQ-014 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-015 ps2_clk and ps2_data SHALL pass a 2-flop synchroniser; ps2_clk SHALL then pass the FILTER_LEN glitch filter.
REQ-016 A sample event SHALL be one cycle when the filtered ps2_clk goes 1->0.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: sample with ps2_data=0 -> DATA, bit count 0; sample with ps2_data=1 ignored.
REQ-019 DATA: each sample shifts ps2_data into bit[count], LSB first; after the 8th -> PARITY.
REQ-020 PARITY: sample stores parity bit -> STOP.
REQ-021 STOP: sample -> IDLE; frame valid iff ps2_data=1 (and parity per REQ-032).
REQ-022 Valid frame SHALL be written on the clk edge ending the STOP sample cycle; ready/level update the following cycle.
REQ-023 Invalid frame (stop=0 or parity fail) SHALL not be written and SHALL pulse frame_err.
REQ-024 In DATA/PARITY/STOP, TIMEOUT_CYC cycles without a sample SHALL force IDLE and pulse frame_err; counter restarts on each sample.
REQ-025 rd_en with ready=1 SHALL advance the read pointer; rd_en with ready=0 SHALL be ignored.
REQ-026 Push and pop in the same cycle SHALL both take effect; level unchanged, including when full.
REQ-027 Push when full without a simultaneous pop SHALL drop the frame and set overflow; FIFO contents unchanged.
REQ-028 overflow SHALL clear on overflow_clr; a new overflow in the same cycle wins.
REQ-029 Pointers SHALL wrap modulo DEPTH; full/empty derived from level, not pointer equality.

Reset
REQ-030 reset SHALL asynchronously force: FSM IDLE, bit count 0, pointers 0, level 0, ready 0, overflow 0, frame_err 0, data 8'h00, timeout counter 0, synchronisers and filter to 1 (line idle).
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the next frame after release SHALL be received normally provided its start bit begins after release.

Configuration
REQ-032 With PS2_RX_PARITY_CHECK_EN defined, frames whose 9 bits (data+parity) have even parity SHALL be invalid; without it, parity SHALL be sampled and ignored.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, PS2_DATA_W=8, PS2_FRAME_BITS=11.
REQ-034 The synchroniser plus glitch filter SHALL be sub-module ps2_sync_filter; FIFO storage stays inline.

Verification
REQ-035 Reset, send frame 0x1C valid parity -> ready=1, data=0x1C, level=1; rd_en 1 cycle -> ready=0, data=0x00.
REQ-036 Send DEPTH+1 frames 0x01..0x09 (DEPTH=8), no reads -> level=8, overflow=1, pops return 0x01..0x08; overflow_clr -> overflow=0.
REQ-037 Frame 0x5A with wrong parity -> with macro: frame_err pulse, level 0; without macro: data=0x5A.
REQ-038 Start bit + 4 data bits then silence TIMEOUT_CYC+1 cycles -> frame_err pulse, FSM IDLE; next frame 0xF0 received intact.
REQ-039 FIFO full, rd_en coincident with push of 0x77 -> level stays 8, overflow=0, 0x77 is last entry.
REQ-040 ps2_clk glitch of FILTER_LEN-1 cycles low mid-bit -> no extra sample; frame 0x3A received correctly.
